user_data_send: RTL and testbench
=================================

# user_data_send

Write-side companion to the DDR3 read test path. It generates a deterministic test burst and pushes it into the DDR3 write FIFO through a valid/ready handshake. After the last beat it issues a one-cycle write-commit request to the DDR3 write engine, then waits for that engine's completion acknowledge. The per-burst seed lets the read-side checker predict every returned word.

## Interface
- USER_DATA_WIDTH, 8, width of each data beat; ≥ 2
- BURST_LEN, 1024, beats per burst; ≥ 2; beat counter width is $clog2(BURST_LEN)

Ports:
- sys_clk  input  1  single clock; all logic on its rising edge
- sys_rst_n  input  1  reset, synchronous, active-low
- ddrc_init_done  input  1  DDR3 controller calibrated; work is permitted only while high
- wr_test_ctrl  input  1  start request; a rising edge (sampled) starts one burst
- user_wr_ready  input  1  write FIFO can accept a beat this cycle (not almost-full)
- user_wr_data  output  USER_DATA_WIDTH  beat payload
- user_wr_data_valid  output  1  user_wr_data is valid; a beat transfers when valid && ready
- user_ddr3_wr_en  output  1  one-cycle commit pulse to the DDR3 write engine
- ddr3_wr_done  input  1  write engine finished the committed burst
- busy  output  1  high in any state other than IDLE
- burst_done  output  1  one-cycle pulse on acknowledged completion

## Operation
- The edge detector holds a registered copy ctrl_d of wr_test_ctrl. start = wr_test_ctrl && !ctrl_d && ddrc_init_done && state==IDLE.
- The state machine has four states: IDLE, FILL, COMMIT, WAIT_ACK.
- IDLE -> FILL on start. The block loads user_wr_data = seed, sets user_wr_data_valid = 1 and clears beat_cnt to 0.
- In FILL, on each valid && ready: beat_cnt increments and user_wr_data increments by 1, modulo 2^USER_DATA_WIDTH.
- While ready is low, valid and data hold exactly. Valid never drops until the beat is accepted.
- FILL -> COMMIT when the beat with beat_cnt == BURST_LEN-1 is accepted. Valid goes low in the same update.
- COMMIT lasts exactly one cycle with user_ddr3_wr_en = 1, then moves to WAIT_ACK.
- ddr3_wr_done is ignored in IDLE, FILL and COMMIT. It is only recognised in WAIT_ACK.
- WAIT_ACK -> IDLE when ddr3_wr_done = 1. burst_done pulses for one cycle and seed <= seed + 1, modulo 2^USER_DATA_WIDTH.
- A start edge while busy is dropped, not queued. Holding wr_test_ctrl high yields exactly one burst.
- If ddrc_init_done falls in any non-IDLE state, the burst aborts:
  - next state is IDLE;
  - valid, wr_en and burst_done all go low;
  - seed is unchanged, so a rerun repeats the same pattern;
  - no commit is issued.
- Abort takes priority over every other transition in the same cycle.

## Timing
- Reset values: user_wr_data = 0, user_wr_data_valid = 0, user_ddr3_wr_en = 0, busy = 0, burst_done = 0, seed = 0, ctrl_d = 0, state = IDLE.
- All outputs are registered.
- Latency from the start cycle (wr_test_ctrl first sampled high) to valid high is 1 cycle.
- With ready held high, the burst occupies exactly BURST_LEN consecutive valid cycles.
- user_ddr3_wr_en rises in the cycle after the last handshake.
- WAIT_ACK is entered one cycle after the pulse. ddr3_wr_done seen there gives burst_done in the next cycle, with busy low in that same cycle.
- Earliest restart: a new start edge may be sampled in the cycle after busy falls.
- Reset asserted mid-burst returns all state to reset values at the next edge. No partial commit is issued.

## Test plan
- Basic burst: reset, hold init_done = 1, ready = 1, pulse wr_test_ctrl. Expect 1024 beats with data 0x00..0xFF repeating (4 wraps), then one wr_en pulse. Drive ddr3_wr_done 3 cycles later and expect burst_done and busy low.
- Backpressure: random ready at about 50%. Expect the beat sequence to be identical, valid and data stable on every ready-low cycle, and exactly 1024 handshakes.
- Seed progression: run three bursts with BURST_LEN = 4. Expect the first beats to be 0, 1, 2, the sequences to be 0-3, 1-4 and 2-5, and one commit per burst.
- Start filtering: hold wr_test_ctrl high for 5000 cycles. Expect one burst only. Also pulse it during FILL and expect no extra burst and no change in count.
- Abort: drop init_done at beat 10. Expect valid low next cycle, no wr_en, state IDLE. Restore init_done and restart; the first beat must equal the old seed.
- Early ack: hold ddr3_wr_done high during FILL and COMMIT. Expect it ignored until WAIT_ACK, then burst_done on the cycle after WAIT_ACK is entered.

Source files
------------

// File: rtl/user_data_send.sv
// user_data_send: emits a deterministic, seed-based write burst into the DDR3
// write FIFO over valid/ready, then pulses a one-cycle commit to the DDR3
// write engine and waits for its completion acknowledge. The seed advances
// once per acknowledged burst so the read-side checker can predict each word.
module user_data_send #(
  parameter int USER_DATA_WIDTH = 8,
  parameter int BURST_LEN       = 1024
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst_n,
  input  logic                       ddrc_init_done,
  input  logic                       wr_test_ctrl,
  input  logic                       user_wr_ready,
  output logic [USER_DATA_WIDTH-1:0] user_wr_data,
  output logic                       user_wr_data_valid,
  output logic                       user_ddr3_wr_en,
  input  logic                       ddr3_wr_done,
  output logic                       busy,
  output logic                       burst_done
);

  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
  localparam logic [USER_DATA_WIDTH-1:0] ONE = USER_DATA_WIDTH'(1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] FILL     = 2'd1;
  localparam logic [1:0] COMMIT   = 2'd2;
  localparam logic [1:0] WAIT_ACK = 2'd3;

  logic [1:0]                 state_reg, state_next;
  logic                       ctrl_d_reg;
  logic [USER_DATA_WIDTH-1:0] seed_reg, seed_next;
  logic [CNT_W-1:0]           cnt_reg, cnt_next;
  logic [USER_DATA_WIDTH-1:0] data_reg, data_next;
  logic                       valid_reg, valid_next;
  logic                       wr_en_reg, wr_en_next;
  logic                       busy_reg, busy_next;
  logic                       done_reg, done_next;
  logic                       start;
  logic                       abort;

  // Next-state logic; an init_done drop outranks every other transition and
  // leaves the seed alone so a rerun replays the same pattern.
  always_comb begin
    start      = wr_test_ctrl && !ctrl_d_reg && ddrc_init_done && (state_reg == IDLE);
    abort      = (state_reg != IDLE) && !ddrc_init_done;
    state_next = state_reg;
    seed_next  = seed_reg;
    cnt_next   = cnt_reg;
    data_next  = data_reg;
    valid_next = valid_reg;
    wr_en_next = 1'b0;
    done_next  = 1'b0;
    if (abort) begin
      state_next = IDLE;
      valid_next = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_next = FILL;
            data_next  = seed_reg;
            valid_next = 1'b1;
            cnt_next   = '0;
          end
        end
        FILL: begin
          if (valid_reg && user_wr_ready) begin
            data_next = data_reg + ONE;
            if (cnt_reg == LAST_BEAT) begin
              valid_next = 1'b0;
              wr_en_next = 1'b1;
              state_next = COMMIT;
            end else begin
              cnt_next = cnt_reg + CNT_W'(1);
            end
          end
        end
        COMMIT: begin
          state_next = WAIT_ACK;
        end
        WAIT_ACK: begin
          if (ddr3_wr_done) begin
            state_next = IDLE;
            done_next  = 1'b1;
            seed_next  = seed_reg + ONE;
          end
        end
        default: begin
          state_next = IDLE;
          valid_next = 1'b0;
        end
      endcase
    end
    busy_next = (state_next != IDLE);
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_reg  <= IDLE;
      ctrl_d_reg <= 1'b0;
      seed_reg   <= '0;
      cnt_reg    <= '0;
      data_reg   <= '0;
      valid_reg  <= 1'b0;
      wr_en_reg  <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      ctrl_d_reg <= wr_test_ctrl;
      seed_reg   <= seed_next;
      cnt_reg    <= cnt_next;
      data_reg   <= data_next;
      valid_reg  <= valid_next;
      wr_en_reg  <= wr_en_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
    end
  end

  assign user_wr_data       = data_reg;
  assign user_wr_data_valid = valid_reg;
  assign user_ddr3_wr_en    = wr_en_reg;
  assign busy               = busy_reg;
  assign burst_done         = done_reg;

endmodule

// File: tb/tb_user_data_send.sv
// tb_user_data_send: randomized-backpressure bench for user_data_send. The
// reference model is the burst rule itself: beat i of a burst carries
// (seed + i) mod 2^W, and the seed counts acknowledged bursts since reset.
module tb_user_data_send;
  localparam int W  = 8;
  localparam int BL = 1024;

  logic         sys_clk = 1'b0;
  logic         sys_rst_n = 1'b0;
  logic         ddrc_init_done = 1'b0;
  logic         wr_test_ctrl = 1'b0;
  logic         user_wr_ready = 1'b0;
  logic         ddr3_wr_done = 1'b0;
  logic [W-1:0] user_wr_data;
  logic         user_wr_data_valid;
  logic         user_ddr3_wr_en;
  logic         busy;
  logic         burst_done;

  int n_cmp = 0;
  int n_err = 0;
  int hs_cnt = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  logic [W-1:0] model_seed = '0;

  always #5 sys_clk = ~sys_clk;

  user_data_send #(.USER_DATA_WIDTH(W), .BURST_LEN(BL)) dut (
    .sys_clk(sys_clk),
    .sys_rst_n(sys_rst_n),
    .ddrc_init_done(ddrc_init_done),
    .wr_test_ctrl(wr_test_ctrl),
    .user_wr_ready(user_wr_ready),
    .user_wr_data(user_wr_data),
    .user_wr_data_valid(user_wr_data_valid),
    .user_ddr3_wr_en(user_ddr3_wr_en),
    .ddr3_wr_done(ddr3_wr_done),
    .busy(busy),
    .burst_done(burst_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Monitor on the falling edge: checks each handshake against the model and
  // that a stalled beat holds valid and data exactly.
  initial begin
    logic         prev_stall;
    logic [W-1:0] prev_data;
    logic [W-1:0] exp_data;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge sys_clk);
      if (!sys_rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid_hold", 32'(user_wr_data_valid), 32'd1);
          check("stall_data_hold", 32'(user_wr_data), 32'(prev_data));
        end
        if (user_wr_data_valid && user_wr_ready) begin
          exp_data = model_seed + W'(hs_cnt);
          check("beat_data", 32'(user_wr_data), 32'(exp_data));
          hs_cnt++;
        end
        if (user_ddr3_wr_en) wr_cnt++;
        if (burst_done) done_cnt++;
        prev_stall = user_wr_data_valid && !user_wr_ready;
        prev_data  = user_wr_data;
      end
    end
  end

  task automatic do_reset();
    sys_rst_n = 1'b0;
    wr_test_ctrl = 1'b0;
    ddr3_wr_done = 1'b0;
    user_wr_ready = 1'b0;
    repeat (3) tick();
    check("rst_data", 32'(user_wr_data), 32'd0);
    check("rst_valid", 32'(user_wr_data_valid), 32'd0);
    check("rst_wr_en", 32'(user_ddr3_wr_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_burst_done", 32'(burst_done), 32'd0);
    sys_rst_n = 1'b1;
    ddrc_init_done = 1'b1;
    model_seed = '0;
    tick();
  endtask

  // One full burst: start pulse, fill under ready_pct backpressure, commit,
  // acknowledge (early or ack_delay cycles after the commit pulse).
  task automatic run_burst(input int ready_pct, input bit early_ack, input int ack_delay,
                           input bit mid_pulse);
    bit seen;
    hs_cnt = 0;
    wr_cnt = 0;
    done_cnt = 0;
    ddr3_wr_done = early_ack;
    user_wr_ready = 1'b0;
    wr_test_ctrl = 1'b1;
    tick();
    wr_test_ctrl = 1'b0;
    check("start_valid", 32'(user_wr_data_valid), 32'd1);
    check("first_beat", 32'(user_wr_data), 32'(model_seed));
    check("busy_fill", 32'(busy), 32'd1);
    seen = 1'b0;
    for (int cyc = 0; cyc < 20 * BL && !seen; cyc++) begin
      if (mid_pulse) wr_test_ctrl = (cyc == 10 || cyc == 300);
      user_wr_ready = ($urandom_range(99) < 32'(ready_pct));
      tick();
      if (user_ddr3_wr_en) seen = 1'b1;
    end
    wr_test_ctrl = 1'b0;
    user_wr_ready = 1'b1;
    check("commit_seen", 32'(seen), 32'd1);
    check("hs_at_commit", 32'(hs_cnt), 32'(BL));
    check("valid_low_commit", 32'(user_wr_data_valid), 32'd0);
    tick();
    check("wr_en_one_cycle", 32'(user_ddr3_wr_en), 32'd0);
    check("busy_wait_ack", 32'(busy), 32'd1);
    if (early_ack) begin
      check("early_ack_ignored", 32'(burst_done), 32'd0);
    end else begin
      for (int i = 1; i < ack_delay; i++) begin
        tick();
        check("busy_before_ack", 32'(busy), 32'd1);
      end
      ddr3_wr_done = 1'b1;
    end
    tick();
    ddr3_wr_done = 1'b0;
    check("burst_done", 32'(burst_done), 32'd1);
    check("busy_after_ack", 32'(busy), 32'd0);
    tick();
    check("done_one_cycle", 32'(burst_done), 32'd0);
    check("done_count", 32'(done_cnt), 32'd1);
    check("commit_count", 32'(wr_cnt), 32'd1);
    check("hs_total", 32'(hs_cnt), 32'(BL));
    $display("burst seed=%0h ready=%0d%% early_ack=%0d beats=%0d commits=%0d",
             model_seed, ready_pct, early_ack, hs_cnt, wr_cnt);
    model_seed = model_seed + W'(1);
  endtask

  initial begin
    do_reset();

    // basic burst, ack three cycles after the commit pulse
    run_burst(100, 1'b0, 3, 1'b0);
    // backpressure at about 50%
    run_burst(50, 1'b0, 2, 1'b0);

    // seed progression from a fresh reset
    do_reset();
    for (int b = 0; b < 3; b++) run_burst(100, 1'b0, 1, 1'b0);

    // start held high for 5000 cycles gives a single burst
    hs_cnt = 0;
    wr_cnt = 0;
    done_cnt = 0;
    user_wr_ready = 1'b1;
    wr_test_ctrl = 1'b1;
    for (int c = 0; c < 5000; c++) begin
      ddr3_wr_done = (wr_cnt > 0) && (done_cnt == 0);
      tick();
    end
    ddr3_wr_done = 1'b0;
    wr_test_ctrl = 1'b0;
    check("hold_done_count", 32'(done_cnt), 32'd1);
    check("hold_commit_count", 32'(wr_cnt), 32'd1);
    check("hold_hs_total", 32'(hs_cnt), 32'(BL));
    check("hold_busy", 32'(busy), 32'd0);
    $display("held start: bursts=%0d commits=%0d beats=%0d", done_cnt, wr_cnt, hs_cnt);
    model_seed = model_seed + W'(1);
    tick();

    // start pulses during FILL are dropped
    run_burst(100, 1'b0, 2, 1'b1);

    // abort at beat 10, then rerun repeats the same seed
    hs_cnt = 0;
    wr_cnt = 0;
    user_wr_ready = 1'b1;
    wr_test_ctrl = 1'b1;
    tick();
    wr_test_ctrl = 1'b0;
    for (int c = 0; c < 100 && hs_cnt < 10; c++) tick();
    ddrc_init_done = 1'b0;
    tick();
    check("abort_valid", 32'(user_wr_data_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_wr_en", 32'(user_ddr3_wr_en), 32'd0);
    repeat (5) tick();
    check("abort_no_commit", 32'(wr_cnt), 32'd0);
    $display("abort after %0d beats: commits=%0d busy=%0d", hs_cnt, wr_cnt, busy);
    ddrc_init_done = 1'b1;
    tick();
    run_burst(100, 1'b0, 2, 1'b0);

    // early ack held through FILL and COMMIT
    run_burst(70, 1'b1, 0, 1'b0);

    // reset in mid-burst: no commit, outputs return to reset values
    hs_cnt = 0;
    wr_cnt = 0;
    wr_test_ctrl = 1'b1;
    tick();
    wr_test_ctrl = 1'b0;
    repeat (20) tick();
    sys_rst_n = 1'b0;
    tick();
    check("midrst_valid", 32'(user_wr_data_valid), 32'd0);
    check("midrst_data", 32'(user_wr_data), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    sys_rst_n = 1'b1;
    model_seed = '0;
    repeat (5) tick();
    check("midrst_no_commit", 32'(wr_cnt), 32'd0);
    $display("reset mid-burst: commits=%0d", wr_cnt);
    run_burst(100, 1'b0, 1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
